// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank: I2C/SCCB responder with an internal byte register bank.
// Define I2C_TARGET_READ_EN to build the bus read path (RDATA/RDATA_ACK, tx shifter).
module i2c_target_regbank #(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter int         DEPTH     = 128,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [6:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  state_t        state;
  logic [1:0]    scl_sy;
  logic [1:0]    sda_sy;
  logic          scl_d;
  logic          sda_d;
  logic [3:0]    cnt;
  logic [7:0]    sh;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic          sda_oe;
  logic [7:0]    bank [DEPTH];
`ifdef I2C_TARGET_READ_EN
  logic [7:0]    tx;
  logic          rw;
`endif

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign host_rdata = bank[host_addr[PW-1:0]];

  assign scl_s    = scl_sy[1];
  assign sda_s    = sda_sy[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

  assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  // Bus line synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], SCL};
      sda_sy <= {sda_sy[0], SDA};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  // Protocol FSM, bank writes and registered bus/strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
`ifdef I2C_TARGET_READ_EN
      tx        <= '0;
      rw        <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= RESET_VAL;
      end
    end else begin
      wr_strobe <= 1'b0;
      if (start) begin
        state  <= ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b1;
      end else if (stop) begin
        state  <= IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise && !cnt[3]) begin
              sh  <= {sh[6:0], sda_s};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt[3]) begin
              cnt <= '0;
              if (sh[7:1] != DEV_ADDR) begin
                state <= IDLE;
`ifdef I2C_TARGET_READ_EN
              end else begin
                rw     <= sh[0];
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end
`else
              end else if (sh[0]) begin
                state <= IDLE;
              end else begin
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end
`endif
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= PTR;
`ifdef I2C_TARGET_READ_EN
              if (rw) begin
                tx     <= bank[ptr];
                sda_oe <= ~bank[ptr][7];
                cnt    <= 4'd1;
                state  <= RDATA;
              end
`endif
            end
          end
          PTR: begin
            if (scl_rise && !cnt[3]) begin
              sh  <= {sh[6:0], sda_s};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt[3]) begin
              ptr    <= PW'(32'(sh) % DEPTH);
              sda_oe <= 1'b1;
              cnt    <= '0;
              state  <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise && !cnt[3]) begin
              sh  <= {sh[6:0], sda_s};
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt[3]) begin
              bank[ptr] <= sh;
              wr_strobe <= 1'b1;
              wr_addr   <= 7'(ptr);
              wr_data   <= sh;
              ptr       <= ptr_inc;
              sda_oe    <= 1'b1;
              cnt       <= '0;
              state     <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
`ifdef I2C_TARGET_READ_EN
          RDATA: begin
            if (scl_fall) begin
              if (cnt[3]) begin
                sda_oe <= 1'b0;
                cnt    <= '0;
                state  <= RDATA_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
                cnt    <= cnt + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (sda_s) begin
                state <= IDLE;
              end
            end else if (scl_fall) begin
              tx     <= bank[ptr];
              sda_oe <= ~bank[ptr][7];
              cnt    <= 4'd1;
              state  <= RDATA;
            end
          end
`endif
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regbank.sv
// tb_i2c_target_regbank: bit-banged bus master with a write scoreboard.
// Build with +define+I2C_TARGET_READ_EN to exercise the read path.
module tb_i2c_target_regbank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        SDA;
  logic [6:0] host_addr = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int total = 0;
  int bad = 0;
  int tgt_low = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_wr[$];

  assign SDA = m_sda_low ? 1'b0 : 1'bz;
  pullup (SDA);

  always #5 clk = ~clk;

  i2c_target_regbank dut (
    .clk        (clk),
    .reset      (rst_n),
    .SCL        (m_scl),
    .SDA        (SDA),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // write monitor: pops one expected write per strobe
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got %0h/%0h want none",
                 wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", int'(wr_addr), int'(e.a));
        check("wr_data", int'(wr_data), int'(e.d));
      end
    end
  end

  // counts cycles the target pulls SDA low
  always @(posedge clk) begin
    if (!m_sda_low && SDA == 1'b0) tgt_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (8) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda_low = 1'b1;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda_low = 1'b0;
    wq();
    wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b;
    wq();
    m_scl = 1'b1;
    wq();
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    b = SDA;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic peek(input logic [6:0] a, input logic [7:0] exp,
                      input string nm);
    host_addr = a;
    #1;
    check(nm, int'(host_rdata), int'(exp));
  endtask

  initial begin
    logic       ak;
    logic [7:0] rb;
    int         l0;

    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sda", int'(SDA), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(wr_strobe), 0);
    for (int i = 0; i < 128; i++) peek(7'(i), 8'h00, "rst_bank");

    // seed bank[0x13] so the pointer can be observed
    i2c_start();
    write_byte(8'h42, ak);
    check("pre_aack", int'(ak), 0);
    write_byte(8'h13, ak);
    check("pre_pack", int'(ak), 0);
    exp_wr.push_back('{a: 7'h13, d: 8'h5A});
    write_byte(8'h5A, ak);
    check("pre_dack", int'(ak), 0);
    i2c_stop();

    // single write
    i2c_start();
    check("t2_busy", int'(busy), 1);
    write_byte(8'h42, ak);
    check("t2_aack", int'(ak), 0);
    write_byte(8'h12, ak);
    check("t2_pack", int'(ak), 0);
    exp_wr.push_back('{a: 7'h12, d: 8'h80});
    write_byte(8'h80, ak);
    check("t2_dack", int'(ak), 0);
    i2c_stop();
    check("t2_idle", int'(busy), 0);
    peek(7'h12, 8'h80, "t2_bank12");
    peek(7'h13, 8'h5A, "t2_bank13");

    // current-address read shows ptr landed on 0x13
    i2c_start();
    write_byte(8'h43, ak);
`ifdef I2C_TARGET_READ_EN
    check("cr_aack", int'(ak), 0);
    read_byte(rb, 1'b1);
    check("cr_data", int'(rb), 8'h5A);
`else
    check("cr_nack", int'(ak), 1);
`endif
    i2c_stop();

    // wrap from 0x7F to 0x00
    i2c_start();
    write_byte(8'h42, ak);
    check("t3_aack", int'(ak), 0);
    write_byte(8'h7F, ak);
    check("t3_pack", int'(ak), 0);
    exp_wr.push_back('{a: 7'h7F, d: 8'hAA});
    write_byte(8'hAA, ak);
    check("t3_d0ack", int'(ak), 0);
    exp_wr.push_back('{a: 7'h00, d: 8'hBB});
    write_byte(8'hBB, ak);
    check("t3_d1ack", int'(ak), 0);
    i2c_stop();
    peek(7'h7F, 8'hAA, "t3_bank7f");
    peek(7'h00, 8'hBB, "t3_bank00");

    // wrong device address
    l0 = tgt_low;
    i2c_start();
    write_byte(8'h40, ak);
    check("t4_aack", int'(ak), 1);
    write_byte(8'h12, ak);
    check("t4_pack", int'(ak), 1);
    write_byte(8'h55, ak);
    check("t4_dack", int'(ak), 1);
    i2c_stop();
    check("t4_sda_low", tgt_low - l0, 0);
    peek(7'h12, 8'h80, "t4_bank12");

    // pointer set, repeated start, read
    i2c_start();
    write_byte(8'h42, ak);
    check("t5_aack", int'(ak), 0);
    write_byte(8'h12, ak);
    check("t5_pack", int'(ak), 0);
    i2c_start();
    write_byte(8'h43, ak);
`ifdef I2C_TARGET_READ_EN
    check("t5_raack", int'(ak), 0);
    read_byte(rb, 1'b0);
    check("t5_rd0", int'(rb), 8'h80);
    read_byte(rb, 1'b1);
    check("t5_rd1", int'(rb), 8'h5A);
    repeat (4) @(posedge clk);
    #1;
    check("t5_release", int'(SDA), 1);
`else
    check("t5_raack", int'(ak), 1);
`endif
    i2c_stop();

    // STOP after four bits of 0x3C
    i2c_start();
    write_byte(8'h42, ak);
    check("t6_aack", int'(ak), 0);
    write_byte(8'h20, ak);
    check("t6_pack", int'(ak), 0);
    write_bit(1'b0);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    i2c_stop();
    check("t6_busy", int'(busy), 0);
    peek(7'h20, 8'h00, "t6_bank20");

    repeat (10) @(posedge clk);
    check("sb_left", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
